// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N-channel arbitrated output register.
package mux_pkg;

    localparam int unsigned MODE_RR   = 0;
    localparam int unsigned MODE_PRIO = 1;

    // Upper bound on channel count accepted by onehot_to_idx.
    localparam int unsigned MAX_CH = 256;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = (value > 0) ? value - 1 : 0;
        r = 0;
        for (int unsigned b = 0; b < 32; b++) begin
            if ((v >> b) != 0) begin
                r = b + 1;
            end
        end
        return r;
    endfunction

    function automatic int unsigned sel_width(input int unsigned nch);
        return (clog2(nch) > 1) ? clog2(nch) : 1;
    endfunction

    function automatic int unsigned onehot_to_idx(input logic [MAX_CH-1:0] onehot);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < MAX_CH; i++) begin
            if (onehot[i]) begin
                idx = idx | i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot arbiter over NCH requests; round-robin from an owned pointer or fixed priority.
module rr_arbiter import mux_pkg::*; #(
    parameter int unsigned NCH  = 2,
    parameter int unsigned MODE = MODE_RR
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NCH-1:0]                req,
    input  logic                          advance,
    output logic [NCH-1:0]                grant,
    output logic [sel_width(NCH)-1:0]     grant_idx
);

    localparam int unsigned SEL_W = sel_width(NCH);

    logic [SEL_W-1:0] w_ptr;
    logic [NCH-1:0]   w_mask;
    logic [NCH-1:0]   w_hi_req;
    logic [NCH-1:0]   w_grant;
    logic             w_found;

    generate
        if (NCH > 1 && MODE == MODE_RR) begin : g_rr
            logic [SEL_W-1:0] r_ptr;
            logic [SEL_W-1:0] w_ptr_next;

            always_comb begin
                w_ptr_next = (grant_idx == SEL_W'(NCH - 1)) ? '0 : grant_idx + 1'b1;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ptr <= '0;
                end else if (advance) begin
                    r_ptr <= w_ptr_next;
                end
            end

            assign w_ptr = r_ptr;
        end else begin : g_no_ptr
            logic w_unused;
            assign w_unused = ^{clk, rst, advance};
            assign w_ptr    = '0;
        end
    endgenerate

    // Search channels at or above the pointer first, then wrap to the lowest
    // request; with the pointer pinned at 0 this degenerates to fixed priority.
    always_comb begin
        w_mask   = '0;
        w_grant  = '0;
        w_found  = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            w_mask[i] = (i >= 32'(w_ptr));
        end
        w_hi_req = req & w_mask;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (!w_found && w_hi_req[i]) begin
                w_grant[i] = 1'b1;
                w_found    = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NCH; i++) begin
            if (!w_found && req[i]) begin
                w_grant[i] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end

    assign grant     = w_grant;
    assign grant_idx = SEL_W'(onehot_to_idx(MAX_CH'(w_grant)));

endmodule

// File: rtl/arb_mux_reg.sv
// N-channel registered selector: arbitrates valid/ready producers onto one output register.
module arb_mux_reg import mux_pkg::*; #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NCH   = 2,
    parameter int unsigned MODE  = MODE_RR
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NCH-1:0]                in_valid,
    input  logic [NCH*WIDTH-1:0]          in_data,
    output logic [NCH-1:0]                in_ready,
    output logic                          out_valid,
    output logic [WIDTH-1:0]              out_data,
    output logic [sel_width(NCH)-1:0]     out_sel,
    input  logic                          out_ready
);

    localparam int unsigned SEL_W = sel_width(NCH);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_sel;

    logic             w_load_en;
    logic             w_any_valid;
    logic             w_advance;
    logic [NCH-1:0]   w_grant;
    logic [SEL_W-1:0] w_grant_idx;
    logic [WIDTH-1:0] w_sel_data;

    assign w_load_en   = ~r_out_valid | out_ready;
    assign w_any_valid = |in_valid;
    assign w_advance   = w_load_en & w_any_valid;

    rr_arbiter #(
        .NCH  (NCH),
        .MODE (MODE)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (in_valid),
        .advance   (w_advance),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    // The output register reads empty during reset, so load_en alone would
    // advertise a handshake; rst masks it.
    assign in_ready = w_grant & {NCH{w_load_en & ~rst}};

    always_comb begin
        w_sel_data = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            w_sel_data = w_sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{w_grant[i]}});
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
        end else if (w_load_en) begin
            if (w_any_valid) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_sel_data;
                r_out_sel   <= w_grant_idx;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule
